// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store port with wait states, lane handling and error checks.
// Optional build macro DMEM_PERF_CNT_EN adds load/store/error counters.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic        rsp_valid,
  output logic [31:0] dReadData,
  output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] cnt_load,
  output logic [31:0] cnt_store,
  output logic [31:0] cnt_err
`endif
);

  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic        accept, commit, mem_wr;
  logic        cur_we, cur_uns;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;
  logic [31:0] offset;
  logic        in_range, misalign, req_err;
  logic [AW-1:0] idx;
  logic [31:0] rd_word, load_val, wr_data, merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  be;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign dReadData = rdata_q;
  assign rsp_err   = err_q;

  // With zero wait states the commit edge is the accept edge, so the live inputs are used.
  assign accept    = (state_q == S_IDLE) && req_valid;
  assign cur_we    = accept ? req_we       : we_q;
  assign cur_size  = accept ? req_size     : size_q;
  assign cur_uns   = accept ? req_unsigned : uns_q;
  assign cur_addr  = accept ? dAddress     : addr_q;
  assign cur_wdata = accept ? dWriteData   : wdata_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) state_d = S_RESP;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign commit   = (state_d == S_RESP);
  assign offset   = cur_addr - BASE_ADDR;
  assign in_range = (offset < SPAN);
  assign misalign = ((cur_size == 2'b01) && cur_addr[0]) ||
                    ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
  assign req_err  = (cur_size == 2'b11) || misalign || !in_range;
  assign idx      = offset[AW+1:2];
  assign rd_word  = mem[idx];
  assign byte_sel = 8'(rd_word >> {cur_addr[1:0], 3'b000});
  assign half_sel = 16'(rd_word >> {cur_addr[1], 4'b0000});

  always_comb begin
    load_val = rd_word;
    be       = 4'b1111;
    wr_data  = cur_wdata;
    case (cur_size)
      2'b00: begin
        load_val = cur_uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        be       = 4'b0001 << cur_addr[1:0];
        wr_data  = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        load_val = cur_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        be       = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_data  = {2{cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Read-modify-write merge: untouched lanes keep their current contents.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = be[gi] ? wr_data[gi*8 +: 8] : rd_word[gi*8 +: 8];
    end
  endgenerate

  // Gated by rst so a store cannot slip into the array while reset is held.
  assign mem_wr = commit && cur_we && !req_err && rst;

  always_ff @(posedge clk) begin
    if (mem_wr) mem[idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= dAddress;
        wdata_q <= dWriteData;
      end
      rdata_q <= (commit && !cur_we && !req_err) ? load_val : 32'd0;
      err_q   <= commit && req_err;
    end
  end

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] cnt_load_q, cnt_store_q, cnt_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_load_q  <= 32'd0;
      cnt_store_q <= 32'd0;
      cnt_err_q   <= 32'd0;
    end else if (state_q == S_RESP) begin
      if (err_q)     cnt_err_q   <= cnt_err_q + 32'd1;
      else if (we_q) cnt_store_q <= cnt_store_q + 32'd1;
      else           cnt_load_q  <= cnt_load_q + 32'd1;
    end
  end

  assign cnt_load  = cnt_load_q;
  assign cnt_store = cnt_store_q;
  assign cnt_err   = cnt_err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model (WAIT_STATES=3).
// Counter checks are included when DMEM_PERF_CNT_EN is defined.
module tb_dmem_responder;

  localparam int          WS    = 3;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h10010000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] dAddress, dWriteData, dReadData;
  logic        rsp_valid, rsp_err;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] cnt_load, cnt_store, cnt_err;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .dAddress     (dAddress),
    .dWriteData   (dWriteData),
    .rsp_valid    (rsp_valid),
    .dReadData    (dReadData),
    .rsp_err      (rsp_err)
`ifdef DMEM_PERF_CNT_EN
    ,
    .cnt_load     (cnt_load),
    .cnt_store    (cnt_store),
    .cnt_err      (cnt_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int exp_ld = 0, exp_st = 0, exp_er = 0;
  logic [7:0] mb [0:4*DEPTH-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: memory as a flat byte array, accesses as byte counts.
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd);
    logic [31:0] off;
    int nbytes;
    off = a - BASE;
    rd  = 32'd0;
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
          (off >= 32'(4 * DEPTH));
    if (err) begin
      exp_er++;
      return;
    end
    nbytes = 1 << sz;
    if (we) begin
      for (int i = 0; i < nbytes; i++) mb[off + 32'(i)] = wd[8*i +: 8];
      exp_st++;
    end else begin
      for (int i = 0; i < nbytes; i++) rd = rd | (32'(mb[off + 32'(i)]) << (8 * i));
      if (nbytes < 4 && !uns && rd[8*nbytes-1]) rd = rd | (32'hFFFFFFFF << (8 * nbytes));
      exp_ld++;
    end
  endfunction

  task automatic xact(input string name, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    logic        e;
    logic [31:0] r;
    model(we, sz, uns, a, wd, e, r);
    @(negedge clk);
    check({name, ".ready_before"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    dAddress = a; dWriteData = wd;
    @(posedge clk);
    for (int k = 1; k <= WS + 1; k++) begin
      @(negedge clk);
      // Inputs are garbage after accept; req_valid stays high through WAIT.
      req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      dAddress = $urandom; dWriteData = $urandom;
      check({name, ".busy"}, req_ready, 0);
      if (k <= WS) begin
        check({name, ".no_early_rsp"}, rsp_valid, 0);
      end else begin
        check({name, ".rsp_valid"}, rsp_valid, 1);
        check({name, ".rsp_err"}, rsp_err, e);
        check({name, ".rdata"}, dReadData, r);
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    check({name, ".ready_after"}, req_ready, 1);
    check({name, ".single_pulse"}, rsp_valid, 0);
    $display("xact %-10s we=%0d sz=%0d uns=%0d addr=%h wd=%h -> exp rd=%h err=%0d",
             name, we, sz, uns, a, wd, r, e);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    dAddress = 32'd0; dWriteData = 32'd0;
    #1;
    check("reset.ready", req_ready, 1);
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.rdata", dReadData, 0);
    check("reset.err", rsp_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Known contents for the region random traffic touches.
    for (int w = 0; w < 64; w++) xact("init", 1'b1, 2'b10, 1'b0, BASE + 32'(4 * w), $urandom);
    xact("init_last", 1'b1, 2'b10, 1'b0, BASE + 32'(4 * (DEPTH - 1)), $urandom);

    xact("sw_beef", 1'b1, 2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF);
    xact("lw_beef", 1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0);
    xact("sw_merge", 1'b1, 2'b10, 1'b0, 32'h10010008, 32'h11223344);
    xact("sb_aa", 1'b1, 2'b00, 1'b0, 32'h1001000A, 32'h000000AA);
    xact("lw_merge", 1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0);
    xact("lb_s", 1'b0, 2'b00, 1'b0, 32'h1001000A, 32'h0);
    xact("lbu", 1'b0, 2'b00, 1'b1, 32'h1001000A, 32'h0);
    xact("lh", 1'b0, 2'b01, 1'b0, 32'h1001000A, 32'h0);
    xact("lw_mis", 1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0);
    xact("sh_mis", 1'b1, 2'b01, 1'b0, 32'h10010001, 32'h1234);
    xact("size11", 1'b0, 2'b11, 1'b0, 32'h10010000, 32'h0);
    xact("lw_oor", 1'b0, 2'b10, 1'b0, BASE + 32'(4 * DEPTH), 32'h0);
    xact("sw_mis_ff", 1'b1, 2'b10, 1'b0, 32'h10010002, 32'hFFFFFFFF);
    xact("lw_word0", 1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0);
    xact("lw_last", 1'b0, 2'b10, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0);

    // Reset abort: store accepted, reset asserted during WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    dAddress = 32'h10010010; dWriteData = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("abort.ready", req_ready, 1);
    check("abort.rsp_valid", rsp_valid, 0);
    for (int k = 0; k < WS + 2; k++) begin
      @(negedge clk);
      check("abort.no_rsp", rsp_valid, 0);
    end
    rst = 1'b1;
    exp_ld = 0; exp_st = 0; exp_er = 0;
    xact("lw_abort", 1'b0, 2'b10, 1'b0, 32'h10010010, 32'h0);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      else if (r == 1) a = BASE - 32'($urandom_range(1, 8));
      else if (r == 2) a = BASE + 32'(4 * (DEPTH - 1)) + 32'($urandom_range(0, 3));
      else             a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
      xact("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end

`ifdef DMEM_PERF_CNT_EN
    check("cnt_load", cnt_load, 32'(exp_ld));
    check("cnt_store", cnt_store, 32'(exp_st));
    check("cnt_err", cnt_err, 32'(exp_er));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
